// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: command sequencer between the byte-level spi_slave
// and an internal register bus.
//
// A command byte (bit7 = read, low bits = start address) opens a
// transaction. Data bytes then stream with address auto-increment:
// writes go out on reg_we, and read data is preloaded into tx_data_reg
// before the next byte. A transaction ends on an inter-byte idle
// timeout or on rx_error.
//
// Ports:
//   sysclk, nreset           clock, async active-low reset
//   enable                   sync enable; low freezes the FSM and timer
//   rx_data_reg/_ready       received byte from spi_slave
//   rx_reg_re                pop pulse to spi_slave
//   tx_data_reg, tx_reg_we   tx hold register and its update pulse
//   tx_reg_empty             spi_slave tx status (read underrun check)
//   rx_error, clear_error    spi_slave overrun flag and its clear pulse
//   reg_addr/_wdata/_we/_re  register bus; reg_rdata valid a cycle
//   reg_rdata                after reg_re
//   busy                     high whenever not IDLE
//   err_flag                 sticky error, cleared by a new command
//
// Optional: define SPI_CTRL_ERRCNT_EN to add err_count[7:0], a
// saturating count of rx_error aborts and read underruns.
module spi_slave_reg_ctrl #(
    parameter int         ADDR_W     = 7,
    parameter int         TIMEOUT    = 1024,
    parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
    input  logic              sysclk,
    input  logic              nreset,
    input  logic              enable,
    input  logic [7:0]        rx_data_reg,
    input  logic              rx_data_ready,
    output logic              rx_reg_re,
    output logic [7:0]        tx_data_reg,
    output logic              tx_reg_we,
    input  logic              tx_reg_empty,
    input  logic              rx_error,
    output logic              clear_error,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              err_flag
`ifdef SPI_CTRL_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR    = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] LOAD  = 3'd3;
    localparam logic [2:0] RD    = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] to_cnt;
    logic             pop_mask;
    logic             clr_mask;
    logic             we_pend;
    logic             tx_pend;

    logic consume;
    logic avail;
    logic err_hit;
    logic byte_ok;
    logic to_hit;
    logic underrun;

    // A byte or error just acted on is masked for one cycle so the
    // spi_slave has time to drop its flag; nothing is taken twice.
    assign consume  = (state == IDLE) || (state == WR) || (state == RD);
    assign avail    = enable && rx_data_ready && !pop_mask;
    assign err_hit  = enable && rx_error && !clr_mask;
    assign byte_ok  = avail && consume && !err_hit;
    assign underrun = byte_ok && (state == RD) && tx_reg_empty;
    assign to_hit   = enable && !err_hit && !byte_ok &&
                      ((state == WR) || (state == RD)) &&
                      (to_cnt == TO_MAX);

    // A pending byte is also drained (and discarded) on an error abort.
    assign rx_reg_re   = avail && (consume || err_hit);
    assign clear_error = err_hit;
    assign reg_re      = enable && (state == FETCH) && !err_hit;
    assign reg_we      = enable && we_pend;
    assign tx_reg_we   = enable && tx_pend;
    assign busy        = (state != IDLE);

    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            pop_mask    <= 1'b0;
            clr_mask    <= 1'b0;
            we_pend     <= 1'b0;
            tx_pend     <= 1'b0;
            tx_data_reg <= DUMMY_BYTE;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            err_flag    <= 1'b0;
        end else if (enable) begin
            pop_mask <= rx_reg_re;
            clr_mask <= err_hit;
            we_pend  <= 1'b0;
            tx_pend  <= 1'b0;

            if ((state == IDLE) || rx_reg_re)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + CNT_W'(1);

            // Post-increment after the write strobe, so reg_we always
            // carries the address the byte was meant for.
            if (we_pend)
                reg_addr <= reg_addr + ADDR_W'(1);

            if (err_hit) begin
                state       <= IDLE;
                err_flag    <= 1'b1;
                tx_data_reg <= DUMMY_BYTE;
                tx_pend     <= 1'b1;
            end else if (to_hit) begin
                state       <= IDLE;
                tx_data_reg <= DUMMY_BYTE;
                tx_pend     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (byte_ok) begin
                            reg_addr <= rx_data_reg[ADDR_W-1:0];
                            err_flag <= 1'b0;
                            state    <= rx_data_reg[7] ? FETCH : WR;
                        end
                    end
                    WR: begin
                        if (byte_ok) begin
                            reg_wdata <= rx_data_reg;
                            we_pend   <= 1'b1;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        tx_data_reg <= reg_rdata;
                        tx_pend     <= 1'b1;
                        state       <= RD;
                    end
                    RD: begin
                        if (byte_ok) begin
                            reg_addr <= reg_addr + ADDR_W'(1);
                            state    <= FETCH;
                            if (underrun)
                                err_flag <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_CTRL_ERRCNT_EN
    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset)
            err_count <= 8'h00;
        else if ((err_hit || underrun) && (err_count != 8'hFF))
            err_count <= err_count + 8'h01;
    end
`endif

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// tb_spi_slave_reg_ctrl: directed bench for spi_slave_reg_ctrl with
// queue scoreboards for register-bus and tx-register traffic.
module tb_spi_slave_reg_ctrl;

    localparam int         AW  = 7;
    localparam int         TO  = 16;
    localparam logic [7:0] DUM = 8'h00;

    logic          sysclk;
    logic          nreset;
    logic          enable;
    logic [7:0]    rx_data_reg;
    logic          rx_data_ready;
    logic          rx_reg_re;
    logic [7:0]    tx_data_reg;
    logic          tx_reg_we;
    logic          tx_reg_empty;
    logic          rx_error;
    logic          clear_error;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata;
    logic          busy;
    logic          err_flag;
`ifdef SPI_CTRL_ERRCNT_EN
    logic [7:0]    err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_clr    = 0;
    int exp_clr  = 0;
    int pc;
    int pc2;

    logic [7:0] mem [0:127];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } we_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } tx_t;

    we_t           exp_we [$];
    tx_t           exp_tx [$];
    logic [AW-1:0] exp_re [$];
    we_t           we_e;
    tx_t           tx_e;
    logic [AW-1:0] re_e;

    spi_slave_reg_ctrl #(
        .ADDR_W     (AW),
        .TIMEOUT    (TO),
        .DUMMY_BYTE (DUM)
    ) dut (
        .sysclk        (sysclk),
        .nreset        (nreset),
        .enable        (enable),
        .rx_data_reg   (rx_data_reg),
        .rx_data_ready (rx_data_ready),
        .rx_reg_re     (rx_reg_re),
        .tx_data_reg   (tx_data_reg),
        .tx_reg_we     (tx_reg_we),
        .tx_reg_empty  (tx_reg_empty),
        .rx_error      (rx_error),
        .clear_error   (clear_error),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
        .reg_rdata     (reg_rdata),
        .busy          (busy),
        .err_flag      (err_flag)
`ifdef SPI_CTRL_ERRCNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Register bus: read data valid the cycle after reg_re.
    always @(posedge sysclk)
        if (reg_re) reg_rdata <= mem[reg_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (nreset) begin
            if (reg_we) begin
                if (exp_we.size() == 0) begin
                    chk("we_unexpected", 32'(reg_we), 32'd0);
                end else begin
                    we_e = exp_we.pop_front();
                    chk("we_addr", 32'(reg_addr), 32'(we_e.a));
                    chk("we_data", 32'(reg_wdata), 32'(we_e.d));
                end
            end
            if (reg_re) begin
                if (exp_re.size() == 0) begin
                    chk("re_unexpected", 32'(reg_re), 32'd0);
                end else begin
                    re_e = exp_re.pop_front();
                    chk("re_addr", 32'(reg_addr), 32'(re_e));
                end
            end
            if (tx_reg_we) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 32'(tx_reg_we), 32'd0);
                end else begin
                    tx_e = exp_tx.pop_front();
                    chk("tx_data", 32'(tx_data_reg), 32'(tx_e.d));
                    if (tx_e.c >= 0)
                        chk("tx_cycle", cyc, tx_e.c);
                end
            end
            if (clear_error) n_clr++;
        end
    end

    // Offer one byte; pc is the cycle it was popped in (-1 if never).
    task automatic send(input logic [7:0] b, output int pcyc);
        bit got;
        got  = 1'b0;
        pcyc = -1;
        @(posedge sysclk); #1;
        rx_data_reg   = b;
        rx_data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (rx_reg_re === 1'b1) begin
                got  = 1'b1;
                pcyc = cyc;
                break;
            end
        end
        @(posedge sysclk); #1;
        if (got) chk("no_double_pop", 32'(rx_reg_re), 32'd0);
        rx_data_ready = 1'b0;
        chk("byte_popped", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge sysclk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge sysclk); while (cyc < target);
    endtask

`ifdef SPI_CTRL_ERRCNT_EN
    task automatic err_pulse();
        exp_tx.push_back(tx_t'{DUM, -1});
        @(posedge sysclk); #1;
        rx_error = 1'b1;
        @(posedge sysclk); #1;
        rx_error = 1'b0;
        exp_clr++;
        @(posedge sysclk); #1;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nreset        = 1'b0;
        enable        = 1'b1;
        rx_data_reg   = 8'h00;
        rx_data_ready = 1'b0;
        tx_reg_empty  = 1'b0;
        rx_error      = 1'b0;
        reg_rdata     = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 1);
        mem[3] = 8'h3C;
        mem[4] = 8'h4D;
        mem[5] = 8'h5E;

        // Reset values
        repeat (3) @(negedge sysclk);
        chk("rst_tx_data", 32'(tx_data_reg), 32'(DUM));
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        chk("rst_strobes", {28'd0, reg_we, reg_re, tx_reg_we, clear_error},
            32'd0);
        @(posedge sysclk); #1;
        nreset = 1'b1;
        repeat (2) @(negedge sysclk);

        // Write burst 0x05, A1, B2, then timeout back to IDLE
        exp_we.push_back(we_t'{7'h05, 8'hA1});
        exp_we.push_back(we_t'{7'h06, 8'hB2});
        send(8'h05, pc);
        chk("wr_busy", 32'(busy), 32'd1);
        send(8'hA1, pc);
        send(8'hB2, pc);
        exp_tx.push_back(tx_t'{DUM, pc + TO + 2});
        wait_cyc(pc + TO + 1);
        chk("wr_to_not_early", 32'(busy), 32'd1);
        @(negedge sysclk);
        chk("wr_to_abort", 32'(busy), 32'd0);
        chk("wr_to_dummy", 32'(tx_data_reg), 32'(DUM));

        // Read burst from address 3
        exp_re.push_back(7'd3);
        send(8'h83, pc);
        exp_tx.push_back(tx_t'{8'h3C, pc + 3});
        repeat (4) @(negedge sysclk);
        chk("rd_first", 32'(tx_data_reg), 32'h3C);
        chk("rd_busy", 32'(busy), 32'd1);
        exp_re.push_back(7'd4);
        send(8'hFF, pc);
        exp_tx.push_back(tx_t'{8'h4D, pc + 3});
        repeat (4) @(negedge sysclk);
        chk("rd_second", 32'(tx_data_reg), 32'h4D);
        chk("rd_no_err", 32'(err_flag), 32'd0);

        // Read underrun: byte arrives with tx_reg_empty high
        tx_reg_empty = 1'b1;
        exp_re.push_back(7'd5);
        send(8'h00, pc);
        tx_reg_empty = 1'b0;
        exp_tx.push_back(tx_t'{8'h5E, pc + 3});
        repeat (4) @(negedge sysclk);
        chk("underrun_flag", 32'(err_flag), 32'd1);
        chk("underrun_continues", 32'(tx_data_reg), 32'h5E);
        exp_tx.push_back(tx_t'{DUM, -1});
        wait_idle(TO + 10);
        chk("rd_to_dummy", 32'(tx_data_reg), 32'(DUM));

        // Address wrap 0x7F -> 0x00; command clears err_flag
        exp_we.push_back(we_t'{7'h7F, 8'h11});
        exp_we.push_back(we_t'{7'h00, 8'h22});
        send(8'h7F, pc);
        chk("cmd_clears_err", 32'(err_flag), 32'd0);
        send(8'h11, pc);
        send(8'h22, pc);
        exp_tx.push_back(tx_t'{DUM, -1});
        wait_idle(TO + 10);

        // rx_error in WR
        exp_we.push_back(we_t'{7'h10, 8'h55});
        send(8'h10, pc);
        send(8'h55, pc);
        exp_tx.push_back(tx_t'{DUM, -1});
        @(posedge sysclk); #1;
        rx_error = 1'b1;
        @(negedge sysclk);
        chk("err_clear_pulse", 32'(clear_error), 32'd1);
        @(posedge sysclk); #1;
        rx_error = 1'b0;
        exp_clr++;
        @(negedge sysclk);
        chk("err_clear_single", 32'(clear_error), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        chk("err_flag_set", 32'(err_flag), 32'd1);
        chk("err_dummy", 32'(tx_data_reg), 32'(DUM));
        send(8'h20, pc);
        chk("err_flag_cleared", 32'(err_flag), 32'd0);
        exp_tx.push_back(tx_t'{DUM, -1});
        wait_idle(TO + 10);

        // Timeout edge: byte on the cycle the counter reaches TIMEOUT
        send(8'h30, pc);
        exp_we.push_back(we_t'{7'h30, 8'h99});
        wait_cyc(pc + TO);
        send(8'h99, pc2);
        chk("edge_pop_cycle", pc2, pc + TO + 1);
        chk("edge_no_abort", 32'(busy), 32'd1);
        exp_tx.push_back(tx_t'{DUM, pc2 + TO + 2});
        wait_cyc(pc2 + TO + 1);
        chk("edge_to_not_early", 32'(busy), 32'd1);
        @(negedge sysclk);
        chk("edge_to_abort", 32'(busy), 32'd0);

        // enable low holds state, timer and the pending byte
        send(8'h40, pc);
        @(posedge sysclk); #1;
        enable        = 1'b0;
        rx_data_reg   = 8'h66;
        rx_data_ready = 1'b1;
        repeat (TO + 5) @(negedge sysclk);
        chk("en_no_pop", 32'(rx_reg_re), 32'd0);
        chk("en_hold_busy", 32'(busy), 32'd1);
        exp_we.push_back(we_t'{7'h40, 8'h66});
        @(posedge sysclk); #1;
        enable = 1'b1;
        @(negedge sysclk);
        chk("en_resume_pop", 32'(rx_reg_re), 32'd1);
        @(posedge sysclk); #1;
        rx_data_ready = 1'b0;
        exp_tx.push_back(tx_t'{DUM, -1});
        wait_idle(TO + 10);

        // nreset in the middle of a write
        send(8'h50, pc);
        @(posedge sysclk); #1;
        rx_data_reg   = 8'h77;
        rx_data_ready = 1'b1;
        @(negedge sysclk);
        chk("rst_mid_pop", 32'(rx_reg_re), 32'd1);
        #1;
        nreset        = 1'b0;
        rx_data_ready = 1'b0;
        @(negedge sysclk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_we", 32'(reg_we), 32'd0);
        chk("rst_mid_addr", 32'(reg_addr), 32'd0);
        chk("rst_mid_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_mid_tx", 32'(tx_data_reg), 32'(DUM));
        @(posedge sysclk); #1;
        nreset = 1'b1;
        repeat (2) @(negedge sysclk);

`ifdef SPI_CTRL_ERRCNT_EN
        chk("cnt_reset", 32'(err_count), 32'd0);
        repeat (3) err_pulse();
        exp_re.push_back(7'd1);
        send(8'h81, pc);
        exp_tx.push_back(tx_t'{mem[1], pc + 3});
        repeat (4) @(negedge sysclk);
        tx_reg_empty = 1'b1;
        exp_re.push_back(7'd2);
        send(8'h00, pc);
        tx_reg_empty = 1'b0;
        exp_tx.push_back(tx_t'{mem[2], pc + 3});
        exp_tx.push_back(tx_t'{DUM, -1});
        wait_idle(TO + 10);
        chk("cnt_four", 32'(err_count), 32'd4);
        repeat (300) err_pulse();
        chk("cnt_saturate", 32'(err_count), 32'hFF);
`endif

        repeat (3) @(negedge sysclk);
        chk("we_queue_empty", 32'(exp_we.size()), 32'd0);
        chk("re_queue_empty", 32'(exp_re.size()), 32'd0);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("clear_error_count", n_clr, exp_clr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
